// File: rtl/serial_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_pkg
// Description : Shared definitions for the parity-protected serial link
//               receiver: deframer FSM state encoding and line-level bit
//               constants.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_frame_pkg;

    // Deframer FSM states (2-bit encoding)
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_e;

    // Line levels
    localparam logic START_BIT  = 1'b1;
    localparam logic STOP_BIT   = 1'b0;
    localparam logic IDLE_LEVEL = 1'b0;

endpackage
`default_nettype wire

// File: rtl/frame_hold_reg.sv
`default_nettype none
// ============================================================================
// Module      : frame_hold_reg
// Description : One-entry valid/ready holding register for received words.
//               Carries the data word, both error flags and a sticky
//               overflow flag set when a load arrives while full and not
//               being drained.
// Ports       : clk, rst_n (async, active-low)
//               i_load, i_data, i_parity_err, i_frame_err : load side
//               i_ready                                   : consumer accept
//               o_valid, o_data, o_parity_err, o_frame_err: held word
//               o_overflow                                : sticky drop flag
// Revision    : 1.0 - initial release
// ============================================================================
module frame_hold_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_parity_err,
    input  logic         i_frame_err,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic         o_parity_err,
    output logic         o_frame_err,
    output logic         o_overflow
);

    logic         r_valid;
    logic [W-1:0] r_data;
    logic         r_parity_err;
    logic         r_frame_err;
    logic         r_overflow;

    logic         w_accept;
    logic         w_free;

    // The slot can take a new word if empty or if it is drained this cycle.
    assign w_accept = r_valid && i_ready;
    assign w_free   = !r_valid || w_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (i_load && w_free) begin
                r_valid      <= 1'b1;
                r_data       <= i_data;
                r_parity_err <= i_parity_err;
                r_frame_err  <= i_frame_err;
            end else if (w_accept) begin
                r_valid      <= 1'b0;
            end
            // Full and not drained: the new word is dropped, contents kept.
            if (i_load && !w_free) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_valid      = r_valid;
    assign o_data       = r_data;
    assign o_parity_err = r_parity_err;
    assign o_frame_err  = r_frame_err;
    assign o_overflow   = r_overflow;

endmodule
`default_nettype wire

// File: rtl/serial_parity_deframer.sv
`default_nettype none
// ============================================================================
// Module      : serial_parity_deframer
// Description : Receive side of the parity-protected serial link. Samples a
//               bit-serial frame (start 1, W data bits LSB first, optional
//               parity, stop 0), reassembles the word, checks parity and
//               stop bit, and presents the result through a one-entry
//               valid/ready holding register.
// Config      : SERIAL_PARITY_CHECK_EN - when defined the frame carries a
//               parity bit which is checked; when undefined there is no
//               parity bit, out_parity_err is 0 and ODD_PARITY is ignored.
// Ports       : clk, rst_n (async, active-low)
//               serial_valid, serial_in     : sampled line bit
//               out_valid, out_ready        : word handshake
//               out_data                    : received word
//               out_parity_err, out_frame_err : per-word error flags
//               overflow                    : sticky, frame dropped
// Revision    : 1.0 - initial release
// ============================================================================
module serial_parity_deframer
    import serial_frame_pkg::*;
#(
    parameter int W          = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         serial_valid,
    input  logic         serial_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_parity_err,
    output logic         out_frame_err,
    output logic         overflow
);

    localparam int            CW     = $clog2(W);
    localparam logic [CW-1:0] C_LAST = CW'(W - 1);

    frame_state_e  r_state;
    logic [CW-1:0] r_count;
    logic [W-1:0]  r_shift;

    logic          w_load;
    logic          w_frame_err;
    logic          w_parity_err;

    // Main deframer FSM; everything advances only on sampled bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_shift <= '0;
        end else if (serial_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (serial_in == START_BIT) begin
                        r_state <= ST_DATA;
                        r_count <= '0;
                    end
                end
                ST_DATA: begin
                    r_shift[r_count] <= serial_in;
                    if (r_count == C_LAST) begin
`ifdef SERIAL_PARITY_CHECK_EN
                        r_state <= ST_PARITY;
`else
                        r_state <= ST_STOP;
`endif
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                ST_PARITY: r_state <= ST_STOP;
                ST_STOP:   r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef SERIAL_PARITY_CHECK_EN
    logic r_parity;
    logic r_parity_err;

    // Running parity seeds with ODD_PARITY so a correct frame folds to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity     <= 1'b0;
            r_parity_err <= 1'b0;
        end else if (serial_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (serial_in == START_BIT) begin
                        r_parity <= ODD_PARITY;
                    end
                end
                ST_DATA:   r_parity     <= r_parity ^ serial_in;
                ST_PARITY: r_parity_err <= r_parity ^ serial_in;
                default:   r_parity     <= r_parity;
            endcase
        end
    end

    assign w_parity_err = r_parity_err;
`else
    logic w_unused_odd_parity;

    assign w_unused_odd_parity = ODD_PARITY;
    assign w_parity_err        = 1'b0;
`endif

    // Frame completes when the stop bit is sampled, even on a framing error.
    assign w_load      = serial_valid && (r_state == ST_STOP);
    assign w_frame_err = (serial_in != STOP_BIT);

    frame_hold_reg #(
        .W (W)
    ) u_hold (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load       (w_load),
        .i_data       (r_shift),
        .i_parity_err (w_parity_err),
        .i_frame_err  (w_frame_err),
        .i_ready      (out_ready),
        .o_valid      (out_valid),
        .o_data       (out_data),
        .o_parity_err (out_parity_err),
        .o_frame_err  (out_frame_err),
        .o_overflow   (overflow)
    );

endmodule
`default_nettype wire

// File: tb/tb_serial_parity_deframer.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_parity_deframer
// Description : Directed self-checking bench for serial_parity_deframer
//               (W=8, even parity; an odd-parity instance is added when
//               SERIAL_PARITY_CHECK_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_parity_deframer;

    logic       clk          = 1'b0;
    logic       rst_n        = 1'b0;
    logic       serial_valid = 1'b0;
    logic       serial_in    = 1'b0;
    logic       out_ready    = 1'b1;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_parity_err;
    logic       out_frame_err;
    logic       overflow;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    serial_parity_deframer #(
        .W          (8),
        .ODD_PARITY (1'b0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .serial_valid   (serial_valid),
        .serial_in      (serial_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_parity_err (out_parity_err),
        .out_frame_err  (out_frame_err),
        .overflow       (overflow)
    );

`ifdef SERIAL_PARITY_CHECK_EN
    logic       odd_valid;
    logic [7:0] odd_data;
    logic       odd_parity_err;
    logic       odd_frame_err;
    logic       odd_overflow;

    serial_parity_deframer #(
        .W          (8),
        .ODD_PARITY (1'b1)
    ) dut_odd (
        .clk            (clk),
        .rst_n          (rst_n),
        .serial_valid   (serial_valid),
        .serial_in      (serial_in),
        .out_valid      (odd_valid),
        .out_ready      (1'b1),
        .out_data       (odd_data),
        .out_parity_err (odd_parity_err),
        .out_frame_err  (odd_frame_err),
        .overflow       (odd_overflow)
    );
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One sampled bit, optionally preceded by 0..max_gap unsampled cycles
    // during which the line carries a misleading 1.
    task automatic send_bit(input logic b, input int max_gap);
        int g;
        g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (g) begin
            serial_valid = 1'b0;
            serial_in    = 1'b1;
            @(posedge clk); #1;
        end
        serial_valid = 1'b1;
        serial_in    = b;
        @(posedge clk); #1;
        serial_valid = 1'b0;
        serial_in    = 1'b0;
    endtask

    // Start bit, data LSB first, and parity when the build carries it.
    task automatic send_head(input logic [7:0] d, input logic flip_par, input int max_gap);
        send_bit(1'b1, max_gap);
        for (int i = 0; i < 8; i++) send_bit(d[i], max_gap);
`ifdef SERIAL_PARITY_CHECK_EN
        send_bit((^d) ^ flip_par, max_gap);
`else
        if (flip_par) begin end
`endif
    endtask

    initial begin
        // ---- Reset state ----
        @(posedge clk); #1;
        chk("rst_valid",    out_valid,      1'b0);
        chk("rst_data",     out_data,       8'h00);
        chk("rst_perr",     out_parity_err, 1'b0);
        chk("rst_ferr",     out_frame_err,  1'b0);
        chk("rst_overflow", overflow,       1'b0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // ---- Good frame A5 ----
        send_head(8'hA5, 1'b0, 0);
        chk("good_pre_valid", out_valid, 1'b0);
        send_bit(1'b0, 0);
        chk("good_valid", out_valid,      1'b1);
        chk("good_data",  out_data,       8'hA5);
        chk("good_perr",  out_parity_err, 1'b0);
        chk("good_ferr",  out_frame_err,  1'b0);
        @(posedge clk); #1;
        chk("good_drained", out_valid, 1'b0);

`ifdef SERIAL_PARITY_CHECK_EN
        // ---- Parity error (even), clean for the odd-parity instance ----
        send_head(8'hA5, 1'b1, 0);
        send_bit(1'b0, 0);
        chk("perr_valid",     out_valid,      1'b1);
        chk("perr_data",      out_data,       8'hA5);
        chk("perr_flag",      out_parity_err, 1'b1);
        chk("perr_ferr",      out_frame_err,  1'b0);
        chk("odd_valid",      odd_valid,      1'b1);
        chk("odd_perr",       odd_parity_err, 1'b0);
        @(posedge clk); #1;
`endif

        // ---- Framing error, then back-to-back good 3C ----
        send_head(8'hA5, 1'b0, 0);
        send_bit(1'b1, 0);
        chk("ferr_valid", out_valid,      1'b1);
        chk("ferr_data",  out_data,       8'hA5);
        chk("ferr_flag",  out_frame_err,  1'b1);
        chk("ferr_perr",  out_parity_err, 1'b0);
        send_head(8'h3C, 1'b0, 0);
        send_bit(1'b0, 0);
        chk("b2b_valid", out_valid,      1'b1);
        chk("b2b_data",  out_data,       8'h3C);
        chk("b2b_ferr",  out_frame_err,  1'b0);
        chk("b2b_perr",  out_parity_err, 1'b0);
        @(posedge clk); #1;

        // ---- Valid gaps, 0..5 cycles between bits ----
        send_head(8'h81, 1'b0, 5);
        send_bit(1'b0, 5);
        chk("gap_valid", out_valid,      1'b1);
        chk("gap_data",  out_data,       8'h81);
        chk("gap_ferr",  out_frame_err,  1'b0);
        chk("gap_perr",  out_parity_err, 1'b0);
        @(posedge clk); #1;

        // ---- Overflow ----
        out_ready = 1'b0;
        send_head(8'h11, 1'b0, 0);
        send_bit(1'b0, 0);
        chk("ovf1_valid", out_valid, 1'b1);
        chk("ovf1_data",  out_data,  8'h11);
        chk("ovf1_flag",  overflow,  1'b0);
        send_head(8'h22, 1'b0, 0);
        send_bit(1'b0, 0);
        chk("ovf2_valid", out_valid, 1'b1);
        chk("ovf2_data",  out_data,  8'h11);
        chk("ovf2_flag",  overflow,  1'b1);
        send_head(8'h33, 1'b0, 0);
        out_ready = 1'b1;
        send_bit(1'b0, 0);
        chk("ovf3_valid", out_valid, 1'b1);
        chk("ovf3_data",  out_data,  8'h33);
        chk("ovf3_flag",  overflow,  1'b1);
        @(posedge clk); #1;
        chk("ovf3_drained", out_valid, 1'b0);

        // ---- Reset mid-frame ----
        send_bit(1'b1, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",    out_valid, 1'b0);
        chk("mid_rst_data",     out_data,  8'h00);
        chk("mid_rst_overflow", overflow,  1'b0);
        chk("mid_rst_ferr",     out_frame_err, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_head(8'h5A, 1'b0, 0);
        send_bit(1'b0, 0);
        chk("post_rst_valid", out_valid,      1'b1);
        chk("post_rst_data",  out_data,       8'h5A);
        chk("post_rst_ferr",  out_frame_err,  1'b0);
        chk("post_rst_perr",  out_parity_err, 1'b0);
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_parity_deframer.md
# serial_parity_deframer

Receive side of the team's parity-protected serial link: samples a bit-serial frame, reassembles the data word, recomputes XOR parity and flags parity and framing errors. Sits between the bit-level line sampler and word-level consumers. Presents each word through a one-entry valid/ready holding register.

## Interface
- `W`, 8: data bits per frame, W ≥ 2.
- `ODD_PARITY`, 0: 0 selects even parity, 1 selects odd.
- `clk` input 1: single clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `serial_valid` input 1: strobe; `serial_in` is sampled only in cycles where this is 1.
- `serial_in` input 1: line bit.
- `out_valid` output 1: holding register holds a word.
- `out_ready` input 1: consumer accepts the word when `out_valid && out_ready`.
- `out_data` output W: received word.
- `out_parity_err` output 1: parity mismatch for `out_data`.
- `out_frame_err` output 1: stop bit was not 0 for `out_data`.
- `overflow` output 1: sticky; a completed frame was dropped.

## Operation
- **Frame format:** idle line is 0. Fields in order: start bit (1), W data bits (LSB first), parity bit, stop bit (0).
- **Parity rule:** the parity bit makes the XOR of data plus parity equal to `ODD_PARITY`.
- **FSM states:** IDLE, DATA, PARITY, STOP. All transitions happen only on sampled bits.
- **IDLE:** sampled 1 moves to DATA. Clear the bit counter and the running parity to `ODD_PARITY`. Sampled 0 stays in IDLE.
- **DATA:** shift the bit into position `count` and XOR it into the running parity. After the W-th bit, go to PARITY.
- **PARITY:** XOR the bit into the running parity. `parity_err` = (running parity != 0). Go to STOP.
- **STOP:** `frame_err` = (bit != 0). Complete the frame and go to IDLE, even on a framing error.
- **Bit counter:** width `$clog2(W)`. Wrap-around is never observed, because the counter resets on every start bit.
- **Completion when the register is free:** load word and both error flags if the holding register is empty, or is being emptied this cycle (`out_valid && out_ready`).
- **Completion when the register is full:** if the holding register is full and not being accepted, drop the new frame. Existing contents are unchanged. Set `overflow`, which is cleared only by reset.
- **Error flags:** `out_parity_err` and `out_frame_err` are meaningful only while `out_valid` = 1. They are held with the word.
- **Output stability:** `out_data` and both flags stay stable while `out_valid && !out_ready`.

## Timing
- **Reset values:** `rst_n` low asynchronously forces FSM IDLE, counter 0, `out_valid` 0, `out_data` 0, both error flags 0, `overflow` 0. A frame in progress is discarded. The first start bit sampled after deassertion begins a new frame.
- **Latency:** `out_valid` rises in the cycle after the stop bit is sampled (registered output).
- **Back-to-back frames:** a start bit may be sampled in the cycle right after the stop bit. No idle gap is required.
- **Valid gaps:** any number of cycles with `serial_valid` = 0 may occur between any two bits. State holds during them.
- **Valid/ready:**
  - `out_valid` falls in the cycle after acceptance, unless a new word loads in that same cycle.
  - Accept and load in the same cycle gives `out_valid` continuously 1 with the new word.

## Configuration
- `SERIAL_PARITY_CHECK_EN` defined: behaviour as above.
- Undefined:
  - The frame has no parity bit; PARITY state is removed, and DATA goes straight to STOP.
  - `out_parity_err` is tied to 0.
  - `ODD_PARITY` is ignored.

## Structure
- **Package `serial_frame_pkg`:**
  - FSM state enum.
  - `START_BIT` = 1'b1, `STOP_BIT` = 1'b0, `IDLE_LEVEL` = 1'b0.
- **Sub-module `frame_hold_reg`:** one-entry valid/ready holding register. It carries data, both error flags and the overflow detect. The deframer FSM feeds it a single-cycle `load` strobe.

## Test plan
- **Good frame:** W=8, even parity, `serial_valid` every cycle. Line: 1, then 1,0,1,0,0,1,0,1, parity 0, stop 0. Expect `out_data`=8'hA5, both error flags 0, `out_valid` one cycle after the stop bit.
- **Parity error:** same frame with parity bit 1. Expect `out_data`=8'hA5, `out_parity_err`=1. With ODD_PARITY=1 and parity bit 1, expect no error.
- **Framing error:** same frame with stop bit 1. Expect `out_frame_err`=1. FSM returns to IDLE, and the next good frame (8'h3C) is received cleanly.
- **Valid gaps:** random gaps of 0–5 cycles on `serial_valid` between bits of 8'h81. Expect 8'h81 with no errors.
- **Overflow:** hold `out_ready`=0 and send 8'h11 then 8'h22. Expect `out_data` to stay 8'h11 and `overflow`=1. Then raise `out_ready` on the cycle the third frame (8'h33) completes. Expect 8'h33 to load with `out_valid` staying 1.
- **Reset mid-frame:** assert `rst_n`=0 after 4 data bits. Expect all outputs 0 immediately. A full 8'h5A frame sent after release is received correctly.
